deg2binary: RTL and testbench



---
 rtl/angle_pkg.sv | 21 ++
 rtl/div360_step.sv | 20 ++
 rtl/deg2binary.sv | 94 +++++++++
 tb/tb_deg2binary.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/angle_pkg.sv
// Shared angle-datapath definitions: widths, degree constants and the
// converter state encoding used by the degree/binary-angle converters.
package angle_pkg;

    localparam int DEG_W  = 14;
    localparam int FRAC_W = 5;
    localparam int BIN_W  = 22;
    localparam int REM_W  = 10;
    localparam int CNT_W  = 5;

    // 360.0 degrees in Q9.5, and the integer divisor for the restoring step
    localparam int DEG_360_Q   = 11520;
    localparam int DEG_DIVISOR = 360;

    typedef enum logic [1:0] {
        IDLE,
        CAL,
        DONE
    } state_t;

endpackage

// File: rtl/div360_step.sv
// One restoring-division step by 360: shifts a dividend bit into the
// remainder and produces the corresponding quotient bit.
module div360_step
    import angle_pkg::*;
(
    input  logic [REM_W-1:0] rem_in,
    input  logic             bit_in,
    output logic [REM_W-1:0] rem_out,
    output logic             q_bit
);

    logic [REM_W:0] trial;

    always_comb begin
        trial   = {rem_in, bit_in};
        q_bit   = (trial >= (REM_W+1)'(DEG_DIVISOR));
        rem_out = q_bit ? REM_W'(trial - (REM_W+1)'(DEG_DIVISOR)) : REM_W'(trial);
    end

endmodule

// File: rtl/deg2binary.sv
// Iterative Q9.5 degrees to binary-angle converter (2^BIN_W = full circle),
// resolving one quotient bit per clock by restoring division by 360.
module deg2binary #(
    parameter int DEG_W  = angle_pkg::DEG_W,
    parameter int FRAC_W = angle_pkg::FRAC_W,
    parameter int BIN_W  = angle_pkg::BIN_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DEG_W-1:0] i_deg,
    output logic [BIN_W-1:0] o_binary,
    output logic             o_finished,
    output logic             o_busy
);

    import angle_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t           state;
    state_t           state_nxt;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_nxt;
    logic [BIN_W-1:0] shf;
    logic [BIN_W-1:0] quo;
    logic [CNT_W-1:0] cnt;
    logic             q_bit;
    logic [DEG_W-1:0] deg_wrap;

    div360_step u_step (
        .rem_in  (rem),
        .bit_in  (shf[BIN_W-1]),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // The 14-bit input never reaches 720 degrees, so one subtraction wraps it
    assign deg_wrap = (i_deg >= DEG_W'(DEG_360_Q)) ? (i_deg - DEG_W'(DEG_360_Q)) : i_deg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = CAL;
            CAL:     if (cnt == LAST_CNT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Integer part seeds the remainder (always < 360); fraction bits lead the dividend
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rem      <= '0;
            shf      <= '0;
            quo      <= '0;
            cnt      <= '0;
            o_binary <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        rem <= REM_W'(deg_wrap[DEG_W-1:FRAC_W]);
                        shf <= {deg_wrap[FRAC_W-1:0], {(BIN_W-FRAC_W){1'b0}}};
                        quo <= '0;
                        cnt <= '0;
                    end
                end
                CAL: begin
                    rem <= rem_nxt;
                    shf <= {shf[BIN_W-2:0], 1'b0};
                    quo <= {quo[BIN_W-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        o_binary <= {quo[BIN_W-2:0], q_bit};
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_finished = (state == DONE);
    assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_deg2binary.sv
// Scoreboard bench for deg2binary: a stimulus process queues expected angles
// from an arithmetic reference, a monitor pops them on every o_finished.
module tb_deg2binary;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [13:0] i_deg;
    logic [21:0] o_binary;
    logic        o_finished;
    logic        o_busy;

    int          checks = 0;
    int          errors = 0;
    logic [21:0] exp_q[$];
    logic [21:0] last_exp;
    logic [21:0] mon_exp;

    always #5 i_clk = ~i_clk;

    deg2binary dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_deg      (i_deg),
        .o_binary   (o_binary),
        .o_finished (o_finished),
        .o_busy     (o_busy)
    );

    // floor(degrees * 2^22 / 360) with degrees = (raw mod 360.0) / 32
    function automatic logic [21:0] ref_model(input logic [13:0] d);
        longint unsigned deg_q;
        deg_q = longint'(d) % 64'd11520;
        return 22'((deg_q << 22) / 64'd11520);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_finished) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_finish: o_binary=0x%0h while no result was pending at %0t",
                         o_binary, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 32'(o_binary), 32'(mon_exp));
                check("busy_at_finish", 32'(o_busy), 32'd1);
            end
        end
    end

    task automatic do_reset();
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_deg   = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst    = 1'b0;
        last_exp = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (o_busy && n < 40) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (o_busy) check("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    // poke: issue a second start with 180 degrees five cycles into the conversion
    task automatic do_conv(input logic [13:0] d, input bit poke);
        bit seen;
        int lat;
        wait_idle();
        check("hold", 32'(o_binary), 32'(last_exp));
        exp_q.push_back(ref_model(d));
        last_exp = ref_model(d);
        i_deg   = d;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            i_deg = 14'($urandom);
            if (poke && n == 5) begin
                i_start = 1'b1;
                i_deg   = 14'd5760;
            end
            @(posedge i_clk);
            #1;
            i_start = 1'b0;
            if (o_finished) begin
                seen = 1'b1;
                lat  = n;
            end else if (!o_busy) begin
                check("busy_during_cal", 32'(o_busy), 32'd1);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL finish_timeout: no o_finished within 40 cycles for i_deg=%0d", d);
        end else begin
            check("latency", 32'(lat), 32'd22);
        end
    endtask

    initial begin
        do_reset();
        check("rst_binary", 32'(o_binary), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_finished", 32'(o_finished), 32'd0);

        do_conv(14'd2880, 1'b0);
        do_conv(14'd0, 1'b0);
        do_conv(14'd5760, 1'b0);
        do_conv(14'd32, 1'b0);
        do_conv(14'd11519, 1'b0);
        do_conv(14'd14400, 1'b0);
        do_conv(14'd11520, 1'b0);
        do_conv(14'd16383, 1'b0);
        do_conv(14'd2880, 1'b1);

        // reset on the tenth CAL cycle: the pending result must be dropped
        wait_idle();
        @(posedge i_clk);
        #1;
        i_deg   = 14'd2880;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (9) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        last_exp = '0;
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_binary", 32'(o_binary), 32'd0);
        check("midrst_finished", 32'(o_finished), 32'd0);
        repeat (30) @(posedge i_clk);
        #1;
        do_conv(14'd5760, 1'b0);

        for (int k = 0; k < 20; k++) begin
            do_conv(14'($urandom_range(0, 16383)), 1'b0);
        end

        wait_idle();
        repeat (5) @(posedge i_clk);
        #1;
        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
